// File: rtl/conv_input_loader_if.sv
// Byte stream handshake into the convolution input loader.
interface conv_input_loader_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_last;

   modport master (output in_valid, in_data, in_last, input in_ready);
   modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/conv_input_loader.sv
// Packs a byte stream into SRAM words at byte-stepped addresses for the conv engine.
// Write strobe 1 cycle after the word-completing byte; in_ready is high only in FILL.
module conv_input_loader #(
   parameter int SRAM_ADDRESS_WIDTH = 12,
   parameter int SRAM_DATA_WIDTH    = 64,
   parameter int BYTES_PER_WORD     = 8,
   parameter int WORD_COUNT         = 129
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   conv_input_loader_if.slave            in_stream,
   output logic [SRAM_ADDRESS_WIDTH-1:0] write_address,
   output logic [SRAM_DATA_WIDTH-1:0]    write_data,
   output logic                          write_enable,
   output logic                          busy,
   output logic                          done,
   output logic                          short_frame
);
   localparam int BI = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam int WI = (WORD_COUNT > 1) ? $clog2(WORD_COUNT + 1) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [BI-1:0] LAST_LANE = BI'(BYTES_PER_WORD - 1);
   localparam logic [WI-1:0] LAST_WORD = WI'(WORD_COUNT - 1);

   logic [1:0]                 state;
   logic [BI-1:0]              byte_idx;
   logic [WI-1:0]              word_idx;
   logic [SRAM_DATA_WIDTH-1:0] pack;
   logic [SRAM_DATA_WIDTH-1:0] pack_next;
   logic                       accept;
   logic                       word_end;

   assign in_stream.in_ready = (state == FILL);
   assign busy               = (state == FILL) || (state == FLUSH);
   assign done               = (state == DONE);
   assign accept             = in_stream.in_valid && (state == FILL);
   assign word_end           = (byte_idx == LAST_LANE) || in_stream.in_last;

   // Lanes above byte_idx are already zero, so a partial word is padded for free.
   always_comb begin
      pack_next = pack;
      pack_next[8*byte_idx +: 8] = in_stream.in_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         byte_idx      <= '0;
         word_idx      <= '0;
         pack          <= '0;
         write_enable  <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
         short_frame   <= 1'b0;
      end else begin
         write_enable <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= FILL;
                  byte_idx    <= '0;
                  word_idx    <= '0;
                  pack        <= '0;
                  short_frame <= 1'b0;
               end
            end
            FILL: begin
               if (accept) begin
                  if (word_end) begin
                     write_enable  <= 1'b1;
                     write_data    <= pack_next;
                     write_address <= SRAM_ADDRESS_WIDTH'(word_idx * BYTES_PER_WORD);
                     word_idx      <= word_idx + 1'b1;
                     byte_idx      <= '0;
                     pack          <= '0;
                     // FLUSH is the cycle carrying the final strobe, so DONE trails it by one.
                     if (in_stream.in_last || (word_idx == LAST_WORD)) begin
                        state       <= FLUSH;
                        short_frame <= in_stream.in_last && (word_idx < LAST_WORD);
                     end
                  end else begin
                     pack     <= pack_next;
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end
            FLUSH:   state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
